// File: rtl/clocked_pulse_stretcher_pkg.sv
`default_nettype none
// ============================================================================
// pulse_stretcher_pkg : state encoding shared by pulse / one-shot blocks
// Rev 1.0
// ============================================================================
package pulse_stretcher_pkg;

    typedef logic [1:0] ps_state_t;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_HIGH = 2'd1;
    localparam logic [1:0] ST_GAP  = 2'd2;

endpackage
`default_nettype wire

// File: rtl/clocked_pulse_stretcher_if.sv
`default_nettype none
// ============================================================================
// clocked_pulse_stretcher_if : trigger/control inputs and pulse status outputs
// Rev 1.0
// ============================================================================
interface clocked_pulse_stretcher_if #(
    parameter int CNT_BITS  = 8,
    parameter int PEND_BITS = 2
);
    logic                 trigger;
    logic [CNT_BITS-1:0]  width;
    logic                 clear;
    logic                 pulse_out;
    logic                 busy;
    logic [PEND_BITS-1:0] pending;
    logic                 overflow;

    modport master (
        output trigger, width, clear,
        input  pulse_out, busy, pending, overflow
    );

    modport slave (
        input  trigger, width, clear,
        output pulse_out, busy, pending, overflow
    );
endinterface
`default_nettype wire

// File: rtl/clocked_down_counter.sv
`default_nettype none
// ============================================================================
// clocked_down_counter : loadable down counter with an "at one" flag
// Rev 1.0
// ============================================================================
module clocked_down_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             enable,
    output logic [WIDTH-1:0] value,
    output logic             is_one
);
    logic [WIDTH-1:0] r_value;

    // load wins over enable so a restart never loses its reload
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_value <= '0;
        end else if (load) begin
            r_value <= load_value;
        end else if (enable) begin
            r_value <= r_value - 1'b1;
        end
    end

    assign value  = r_value;
    assign is_one = (r_value == WIDTH'(1));
endmodule
`default_nettype wire

// File: rtl/clocked_pulse_stretcher.sv
`default_nettype none
// ============================================================================
// clocked_pulse_stretcher : stretches strobes into timed pulses with a low gap,
//                           queuing triggers that arrive while busy
// Rev 1.0
// ============================================================================
module clocked_pulse_stretcher
    import pulse_stretcher_pkg::*;
#(
    parameter int CNT_BITS    = 8,
    parameter int GAP_CYCLES  = 2,
    parameter int PEND_BITS   = 2,
    parameter int MAX_PENDING = 3
) (
    input  logic                     clk,
    input  logic                     rst_n,
    clocked_pulse_stretcher_if.slave bus
);
    localparam int                   GAP_BITS   = $clog2(GAP_CYCLES + 1);
    localparam logic [GAP_BITS-1:0]  C_GAP_LOAD = GAP_BITS'(GAP_CYCLES);
    localparam logic [PEND_BITS-1:0] C_MAX_PEND = PEND_BITS'(MAX_PENDING);

    ps_state_t            r_state;
    ps_state_t            w_state_nxt;
    logic [PEND_BITS-1:0] r_pending;
    logic [PEND_BITS-1:0] w_pending_nxt;
    logic                 r_overflow;
    logic                 r_pulse;
    logic                 r_busy;
    logic                 w_drop;

    logic [CNT_BITS-1:0]  w_width_load;
    logic [CNT_BITS-1:0]  w_width_value;
    logic                 w_width_one;
    logic [GAP_BITS-1:0]  w_gap_value;
    logic                 w_gap_one;

    logic w_restart;
    logic w_start;
    logic w_dequeue;
    logic w_trig_busy;

    assign w_restart   = (r_state == ST_GAP) && w_gap_one &&
                         ((r_pending != '0) || bus.trigger);
    assign w_start     = ((r_state == ST_IDLE) && bus.trigger) || w_restart;
    assign w_dequeue   = w_restart && (r_pending != '0);
    assign w_trig_busy = bus.trigger && (r_state != ST_IDLE);
    assign w_width_load = (bus.width == '0) ? CNT_BITS'(1) : bus.width;

    clocked_down_counter #(.WIDTH(CNT_BITS)) u_width_cnt (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (w_start),
        .load_value (w_width_load),
        .enable     ((r_state == ST_HIGH) && (w_width_value > CNT_BITS'(1))),
        .value      (w_width_value),
        .is_one     (w_width_one)
    );

    clocked_down_counter #(.WIDTH(GAP_BITS)) u_gap_cnt (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       ((r_state == ST_HIGH) && w_width_one),
        .load_value (C_GAP_LOAD),
        .enable     ((r_state == ST_GAP) && (w_gap_value > GAP_BITS'(1))),
        .value      (w_gap_value),
        .is_one     (w_gap_one)
    );

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (bus.trigger) w_state_nxt = ST_HIGH;
            ST_HIGH: if (w_width_one) w_state_nxt = ST_GAP;
            ST_GAP:  if (w_gap_one)   w_state_nxt = w_restart ? ST_HIGH : ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // A restart with a queued entry and a fresh trigger nets to no change;
    // a restart with an empty queue consumes the fresh trigger directly.
    always_comb begin
        w_pending_nxt = r_pending;
        w_drop        = 1'b0;
        if (w_restart) begin
            if (w_dequeue && !bus.trigger) begin
                w_pending_nxt = r_pending - 1'b1;
            end
        end else if (w_trig_busy) begin
            if (r_pending == C_MAX_PEND) begin
                w_drop = 1'b1;
            end else begin
                w_pending_nxt = r_pending + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_pending  <= '0;
            r_overflow <= 1'b0;
            r_pulse    <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_pending <= w_pending_nxt;
            r_pulse   <= (w_state_nxt == ST_HIGH);
            r_busy    <= (w_state_nxt != ST_IDLE);
            if (w_drop) begin
                r_overflow <= 1'b1;
            end else if (bus.clear) begin
                r_overflow <= 1'b0;
            end
        end
    end

    assign bus.pulse_out = r_pulse;
    assign bus.busy      = r_busy;
    assign bus.pending   = r_pending;
    assign bus.overflow  = r_overflow;
endmodule
`default_nettype wire

// File: tb/tb_clocked_pulse_stretcher.sv
`default_nettype none
// ============================================================================
// tb_clocked_pulse_stretcher : vector table, corner sequences, random vs model
// Rev 1.0
// ============================================================================
module tb_clocked_pulse_stretcher;
    localparam int GAP  = 2;
    localparam int MAXP = 3;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;
    int   cyc;

    clocked_pulse_stretcher_if #(.CNT_BITS(8), .PEND_BITS(2)) bus ();

    clocked_pulse_stretcher #(
        .CNT_BITS(8), .GAP_CYCLES(GAP), .PEND_BITS(2), .MAX_PENDING(MAXP)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Timeline model: t counts edges since the current pulse started.
    bit m_act;
    int m_t;
    int m_w;
    int m_pend;
    bit m_ovf;

    function automatic void model_reset();
        m_act = 0; m_t = 0; m_w = 0; m_pend = 0; m_ovf = 0;
    endfunction

    function automatic void model_edge(input bit trig, input int width, input bit clr);
        bit drop;
        drop = 0;
        if (!m_act) begin
            if (trig) begin
                m_act = 1; m_t = 0; m_w = (width == 0) ? 1 : width;
            end
        end else begin
            m_t = m_t + 1;
            if (m_t == m_w + GAP) begin
                if (m_pend > 0 || trig) begin
                    if (m_pend > 0 && !trig) m_pend = m_pend - 1;
                    m_t = 0; m_w = (width == 0) ? 1 : width;
                end else begin
                    m_act = 0;
                end
            end else if (trig) begin
                if (m_pend == MAXP) drop = 1;
                else m_pend = m_pend + 1;
            end
        end
        if (drop) m_ovf = 1;
        else if (clr) m_ovf = 0;
    endfunction

    task automatic chk(input string name, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%0d exp=%0d", name, cyc, got, exp);
        end
    endtask

    task automatic chk_model();
        chk("pulse",    int'(bus.pulse_out), int'(m_act && (m_t < m_w)));
        chk("busy",     int'(bus.busy),      int'(m_act));
        chk("pending",  int'(bus.pending),   m_pend);
        chk("overflow", int'(bus.overflow),  int'(m_ovf));
    endtask

    task automatic step(input bit trig, input int width, input bit clr);
        bus.trigger = trig;
        bus.width   = 8'(width);
        bus.clear   = clr;
        @(posedge clk);
        model_edge(trig, width, clr);
        #1;
        cyc++;
        chk_model();
        bus.trigger = 1'b0;
        bus.clear   = 1'b0;
    endtask

    // Asserted and released between edges to exercise the asynchronous path.
    task automatic async_reset();
        rst_n = 1'b0;
        #2;
        model_reset();
        chk("rst_pulse",    int'(bus.pulse_out), 0);
        chk("rst_busy",     int'(bus.busy),      0);
        chk("rst_pending",  int'(bus.pending),   0);
        chk("rst_overflow", int'(bus.overflow),  0);
        #1;
        rst_n = 1'b1;
    endtask

    typedef struct {
        bit trig; int width; bit clr;
        bit p; bit b; int n; bit o;
    } vec_t;
    vec_t tbl[$];

    function automatic void add(input bit t, input int w, input bit c,
                                input bit p, input bit b, input int n, input bit o);
        vec_t v;
        v.trig = t; v.width = w; v.clr = c; v.p = p; v.b = b; v.n = n; v.o = o;
        tbl.push_back(v);
    endfunction

    initial begin
        int  npulse;
        bit  prev;
        total = 0; bad = 0; cyc = 0;
        bus.trigger = 1'b0; bus.width = 8'd0; bus.clear = 1'b0;
        rst_n = 1'b0;
        model_reset();

        // single Width=4 pulse
        add(1,4,0, 1,1,0,0); add(0,4,0, 1,1,0,0); add(0,4,0, 1,1,0,0);
        add(0,4,0, 1,1,0,0); add(0,4,0, 0,1,0,0); add(0,4,0, 0,1,0,0);
        add(0,4,0, 0,0,0,0);
        // Width=0 behaves as one cycle
        add(1,0,0, 1,1,0,0); add(0,0,0, 0,1,0,0); add(0,0,0, 0,1,0,0);
        add(0,0,0, 0,0,0,0);
        // Width=3, triggers at relative edges 0,2,3
        add(1,3,0, 1,1,0,0); add(0,3,0, 1,1,0,0); add(1,3,0, 1,1,1,0);
        add(1,3,0, 0,1,2,0); add(0,3,0, 0,1,2,0); add(0,3,0, 1,1,1,0);
        add(0,3,0, 1,1,1,0); add(0,3,0, 1,1,1,0); add(0,3,0, 0,1,1,0);
        add(0,3,0, 0,1,1,0); add(0,3,0, 1,1,0,0); add(0,3,0, 1,1,0,0);
        add(0,3,0, 1,1,0,0); add(0,3,0, 0,1,0,0); add(0,3,0, 0,1,0,0);
        add(0,3,0, 0,0,0,0);

        repeat (3) @(posedge clk);
        #1;
        chk("reset_pulse",    int'(bus.pulse_out), 0);
        chk("reset_busy",     int'(bus.busy),      0);
        chk("reset_pending",  int'(bus.pending),   0);
        chk("reset_overflow", int'(bus.overflow),  0);
        rst_n = 1'b1;
        repeat (2) step(0, 4, 0);

        foreach (tbl[i]) begin
            step(tbl[i].trig, tbl[i].width, tbl[i].clr);
            chk("tbl_pulse",    int'(bus.pulse_out), int'(tbl[i].p));
            chk("tbl_busy",     int'(bus.busy),      int'(tbl[i].b));
            chk("tbl_pending",  int'(bus.pending),   tbl[i].n);
            chk("tbl_overflow", int'(bus.overflow),  int'(tbl[i].o));
        end

        // saturation: Width=8, five triggers during the first pulse
        npulse = 0;
        step(1, 8, 0);
        prev = bus.pulse_out;
        npulse = int'(prev);
        for (int i = 0; i < 5; i++) begin
            step(1, 8, 0);
            if (bus.pulse_out && !prev) npulse++;
            prev = bus.pulse_out;
        end
        chk("sat_pending",  int'(bus.pending),  3);
        chk("sat_overflow", int'(bus.overflow), 1);
        for (int i = 0; i < 100 && bus.busy; i++) begin
            step(0, 8, 0);
            if (bus.pulse_out && !prev) npulse++;
            prev = bus.pulse_out;
        end
        chk("sat_idle", int'(bus.busy), 0);
        chk("sat_pulse_count", npulse, 4);
        step(0, 8, 1);
        chk("clear_overflow", int'(bus.overflow), 0);

        // trigger coincident with last gap cycle, Pending=1 then Pending=0
        step(1, 2, 0); step(1, 2, 0); step(0, 2, 0); step(0, 2, 0);
        step(1, 2, 0);
        chk("coinc1_pulse",   int'(bus.pulse_out), 1);
        chk("coinc1_pending", int'(bus.pending),   1);
        repeat (3) step(0, 2, 0);
        step(0, 2, 0);
        chk("dequeue_pending", int'(bus.pending), 0);
        repeat (3) step(0, 2, 0);
        step(1, 2, 0);
        chk("coinc0_pulse",   int'(bus.pulse_out), 1);
        chk("coinc0_pending", int'(bus.pending),   0);
        repeat (4) step(0, 2, 0);

        // reset in the middle of pulse 2 with two queued triggers
        repeat (4) step(1, 5, 0);
        repeat (4) step(0, 5, 0);
        chk("pre_rst_pending", int'(bus.pending),   2);
        chk("pre_rst_pulse",   int'(bus.pulse_out), 1);
        async_reset();
        repeat (6) step(0, 5, 0);
        chk("post_rst_busy", int'(bus.busy), 0);

        // randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(199) == 0) begin
                async_reset();
            end
            step($urandom_range(99) < 30, int'($urandom_range(7)),
                 $urandom_range(99) < 5);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
